// File: rtl/crc_stream.sv
// crc_stream: streaming sop/eop-framed CRC generator/checker with a valid/ready result port
module crc_stream #(
  parameter int CRC_W = 5,
  parameter logic [CRC_W-1:0] POLY = 'h05,
  parameter logic [CRC_W-1:0] INIT = 'h1F,
  parameter logic [CRC_W-1:0] XOROUT = 'h1F,
  parameter logic [CRC_W-1:0] RESIDUE = 'h0C,
  parameter int DATA_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_sop,
  input  logic                          in_eop,
  input  logic [$clog2(DATA_W+1)-1:0]   in_nbits,
  input  logic [DATA_W-1:0]             data_in,
  output logic                          crc_valid,
  input  logic                          crc_ready,
  output logic [CRC_W-1:0]              crc_out,
  output logic                          crc_match,
  output logic                          in_err
);
  localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [CRC_W-1:0] lfsr, nxt;
  logic xfer, retire, take, err;
  int n;
  function automatic logic [CRC_W-1:0] step(input logic [CRC_W-1:0] s, input logic [DATA_W-1:0] d, input int nb);
    logic [CRC_W-1:0] c;
    c = s;
    for (int i = 0; i < DATA_W; i++)
      if (i < nb) c = (c << 1) ^ ((c[CRC_W-1] ^ d[i]) ? POLY : '0);
    return c;
  endfunction
  assign in_ready = !crc_valid | crc_ready;
  always_comb begin
    xfer = in_valid & in_ready;
    retire = crc_valid & crc_ready;
    take = xfer & (in_sop | state == ACCUM);
    err = xfer & (in_sop ? state == ACCUM : state != ACCUM);
    n = (in_eop && in_nbits != '0 && int'(in_nbits) <= DATA_W) ? int'(in_nbits) : DATA_W;
    nxt = step(in_sop ? INIT : lfsr, data_in, n);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr <= INIT;
      crc_valid <= 1'b0;
      crc_out <= '0;
      crc_match <= 1'b0;
      in_err <= 1'b0;
    end else begin
      in_err <= err;
      if (retire) crc_valid <= 1'b0;
      if (take) begin
        lfsr <= nxt;
        state <= in_eop ? DONE : ACCUM;
        if (in_eop) begin
          crc_valid <= 1'b1;
          crc_out <= nxt ^ XOROUT;
          crc_match <= nxt == RESIDUE;
        end
      end else if (retire) begin
        lfsr <= INIT;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_crc_stream.sv
// tb_crc_stream: directed checks of crc_stream in USB CRC5 and CRC16 configurations
module tb_crc_stream;
  logic clk = 1'b0, rst = 1'b1;
  logic v = 1'b0, sop = 1'b0, eop = 1'b0, cr = 1'b0, rdy, cv, cm, er;
  logic [3:0] nb = '0;
  logic [7:0] d = '0;
  logic [4:0] co;
  logic v16 = 1'b0, sop16 = 1'b0, eop16 = 1'b0, rdy16, cv16, cm16, er16;
  logic [3:0] nb16 = 4'd8;
  logic [7:0] d16 = '0;
  logic [15:0] co16, e16;
  logic [7:0] pkt [0:65];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  crc_stream dut5 (.clk(clk), .rst(rst), .in_valid(v), .in_ready(rdy), .in_sop(sop), .in_eop(eop),
    .in_nbits(nb), .data_in(d), .crc_valid(cv), .crc_ready(cr), .crc_out(co), .crc_match(cm), .in_err(er));
  crc_stream #(.CRC_W(16), .POLY(16'h8005), .INIT(16'hFFFF), .XOROUT(16'hFFFF), .RESIDUE(16'h800D), .DATA_W(8)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .in_sop(sop16), .in_eop(eop16),
    .in_nbits(nb16), .data_in(d16), .crc_valid(cv16), .crc_ready(1'b1), .crc_out(co16), .crc_match(cm16), .in_err(er16));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic s, input logic e, input logic [3:0] b, input logic [7:0] x);
    int t = 0;
    v = 1'b1; sop = s; eop = e; nb = b; d = x;
    while (!rdy && t < 20) begin tick(); t++; end
    if (t == 20) chk("rdy_wait", {31'd0, rdy}, 32'd1);
    tick();
    v = 1'b0; sop = 1'b0; eop = 1'b0;
  endtask
  task automatic take(input string tag, input logic [4:0] eo, input logic em);
    chk({tag, "_valid"}, {31'd0, cv}, 32'd1);
    chk({tag, "_crc"}, {27'd0, co}, {27'd0, eo});
    chk({tag, "_match"}, {31'd0, cm}, {31'd0, em});
    cr = 1'b1;
    tick();
    cr = 1'b0;
    chk({tag, "_retire"}, {31'd0, cv}, 32'd0);
  endtask
  function automatic logic [15:0] ref16(input int len);
    logic [15:0] r, o;
    r = 16'hFFFF;
    for (int k = 0; k < len; k++) begin
      r ^= {8'h00, pkt[k]};
      for (int j = 0; j < 8; j++) r = r[0] ? (r >> 1) ^ 16'hA001 : r >> 1;
    end
    r ^= 16'hFFFF;
    for (int j = 0; j < 16; j++) o[j] = r[15-j];
    return o;
  endfunction
  task automatic send16(input int len);
    for (int k = 0; k < len; k++) begin
      v16 = 1'b1; sop16 = k == 0; eop16 = k == len - 1; d16 = pkt[k];
      tick();
    end
    v16 = 1'b0; sop16 = 1'b0; eop16 = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int lens [7] = '{0, 1, 2, 3, 9, 33, 64};
    repeat (2) tick();
    chk("rst_valid", {31'd0, cv}, 32'd0);
    chk("rst_crc", {27'd0, co}, 32'd0);
    chk("rst_match", {31'd0, cm}, 32'd0);
    chk("rst_err", {31'd0, er}, 32'd0);
    chk("rst_ready", {31'd0, rdy}, 32'd1);
    rst = 1'b0;
    tick();
    beat(1, 0, 3, 8'h00); beat(0, 1, 3, 8'h00);
    take("gen", 5'h08, 1'b0);
    beat(1, 0, 0, 8'h00); beat(0, 1, 8, 8'h10);
    take("chk_ok", 5'h13, 1'b1);
    beat(1, 0, 0, 8'h00); beat(0, 1, 0, 8'h18);
    take("chk_bad", 5'h09, 1'b0);
    beat(1, 0, 0, 8'h00); beat(0, 1, 15, 8'h10);
    take("nbits15", 5'h13, 1'b1);
    beat(1, 0, 0, 8'h00); beat(0, 1, 3, 8'h00);
    v = 1'b1; sop = 1'b1; eop = 1'b0; nb = 4'd0; d = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ready", {31'd0, rdy}, 32'd0);
      chk("bp_valid", {31'd0, cv}, 32'd1);
      chk("bp_crc", {27'd0, co}, 32'h08);
    end
    cr = 1'b1;
    #1 chk("bp_release", {31'd0, rdy}, 32'd1);
    tick();
    cr = 1'b0; v = 1'b0; sop = 1'b0;
    chk("bp_retired", {31'd0, cv}, 32'd0);
    beat(0, 1, 3, 8'h00);
    take("bp_next", 5'h08, 1'b0);
    beat(1, 0, 3, 8'h00); beat(0, 1, 3, 8'h00);
    cr = 1'b1;
    beat(1, 1, 8, 8'h00);
    cr = 1'b0;
    take("sopeop", 5'h10, 1'b0);
    beat(0, 0, 0, 8'hAA);
    chk("idle_err", {31'd0, er}, 32'd1);
    chk("idle_noresult", {31'd0, cv}, 32'd0);
    tick();
    chk("err_pulse", {31'd0, er}, 32'd0);
    beat(1, 0, 0, 8'hFF); beat(1, 0, 0, 8'h00);
    chk("abort_err", {31'd0, er}, 32'd1);
    beat(0, 1, 3, 8'h00);
    chk("abort_err_clr", {31'd0, er}, 32'd0);
    take("abort", 5'h08, 1'b0);
    beat(1, 0, 0, 8'h00);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstmid_valid", {31'd0, cv}, 32'd0);
    chk("rstmid_ready", {31'd0, rdy}, 32'd1);
    beat(0, 1, 3, 8'h00);
    chk("rstmid_discard", {31'd0, er}, 32'd1);
    beat(1, 0, 3, 8'h00); beat(0, 1, 3, 8'h00);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstres_valid", {31'd0, cv}, 32'd0);
    chk("rstres_ready", {31'd0, rdy}, 32'd1);
    chk("rstres_crc", {27'd0, co}, 32'd0);
    beat(1, 0, 3, 8'h00); beat(0, 1, 3, 8'h00);
    take("post_rst", 5'h08, 1'b0);
    for (int k = 0; k < 9; k++) pkt[k] = 8'h31 + 8'(k);
    send16(9);
    chk("c16_known", {16'd0, co16}, 32'h132D);
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < lens[i]; k++) pkt[k] = 8'($urandom);
      e16 = ref16(lens[i]);
      if (lens[i] > 0) begin
        send16(lens[i]);
        chk("c16_valid", {31'd0, cv16}, 32'd1);
        chk("c16_crc", {16'd0, co16}, {16'd0, e16});
      end
      for (int j = 0; j < 8; j++) begin
        pkt[lens[i]][j] = e16[15-j];
        pkt[lens[i]+1][j] = e16[7-j];
      end
      send16(lens[i] + 2);
      chk("c16_match", {31'd0, cm16}, 32'd1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
